dbus_ctrl: RTL

DBUS_CTRL -- requirements
Module: dbus_ctrl

---
 rtl/dbus_ctrl_if.sv | 27 ++
 rtl/dbus_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/dbus_ctrl_if.sv
// dbus_ctrl_if: core memory-stage request port plus external bus port of dbus_ctrl
interface dbus_ctrl_if;
  logic        c_req;
  logic        c_write;
  logic [1:0]  c_size;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [31:0] c_rdata;
  logic        c_stall;
  logic        c_fault;
  logic        b_mreq;
  logic        b_write;
  logic [1:0]  b_size;
  logic [31:0] b_addr;
  logic [31:0] b_dout;
  logic        b_oe;
  logic [31:0] b_din;
  logic        b_ack_n;
  modport master (
    output c_req, c_write, c_size, c_addr, c_wdata, b_din, b_ack_n,
    input  c_rdata, c_stall, c_fault, b_mreq, b_write, b_size, b_addr, b_dout, b_oe
  );
  modport slave (
    input  c_req, c_write, c_size, c_addr, c_wdata, b_din, b_ack_n,
    output c_rdata, c_stall, c_fault, b_mreq, b_write, b_size, b_addr, b_dout, b_oe
  );
endinterface

// File: rtl/dbus_ctrl.sv
// dbus_ctrl: core data-access to external bus bridge with alignment fault detection.
// Optional access timeout enabled by defining BUS_TIMEOUT_EN.
module dbus_ctrl #(
  parameter int TIMEOUT = 15
) (
  input logic       clk,
  input logic       rst,
  dbus_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t      state_q, state_d;
  logic        mreq_q, mreq_d, write_q, write_d, fault_q, fault_d, aligned;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, dout_q, dout_d, rdata_q, rdata_d, repl;
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end
`ifdef BUS_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
`endif
  always_comb begin
    aligned = bus.c_size == 2'b00 || (bus.c_size == 2'b01 && !bus.c_addr[0]) ||
              (bus.c_size == 2'b10 && bus.c_addr[1:0] == 2'b00);
    repl = bus.c_size == 2'b00 ? {4{bus.c_wdata[7:0]}} :
           bus.c_size == 2'b01 ? {2{bus.c_wdata[15:0]}} : bus.c_wdata;
    state_d = state_q;
    mreq_d  = mreq_q;
    write_d = write_q;
    size_d  = size_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rdata_d = rdata_q;
    fault_d = 1'b0;
`ifdef BUS_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: if (bus.c_req) begin
        if (aligned) begin
          state_d = ACCESS;
          mreq_d  = 1'b1;
          write_d = bus.c_write;
          size_d  = bus.c_size;
          addr_d  = bus.c_addr;
          dout_d  = repl;
`ifdef BUS_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end else begin
          state_d = DONE;
          fault_d = 1'b1;
        end
      end
      ACCESS: if (!bus.b_ack_n) begin
        state_d = DONE;
        mreq_d  = 1'b0;
        rdata_d = write_q ? rdata_q : bus.b_din;
      end
`ifdef BUS_TIMEOUT_EN
      // ack is tested first so a late ack on the limit cycle still completes normally
      else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d = DONE;
        mreq_d  = 1'b0;
        fault_d = 1'b1;
        rdata_d = '0;
      end else cnt_d = cnt_q + 1'b1;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mreq_q  <= 1'b0;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= '0;
      dout_q  <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      mreq_q  <= mreq_d;
      write_q <= write_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
`ifdef BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end
  assign bus.c_stall = (state_q == IDLE && bus.c_req && aligned) || state_q == ACCESS;
  assign bus.c_rdata = rdata_q;
  assign bus.c_fault = fault_q;
  assign bus.b_mreq  = mreq_q;
  assign bus.b_write = write_q;
  assign bus.b_size  = size_q;
  assign bus.b_addr  = addr_q;
  assign bus.b_dout  = dout_q;
  assign bus.b_oe    = mreq_q & write_q;
endmodule
